// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
// Shared constants for the fetch/PC sequencer: FSM state encoding, default
// reset/trap vectors and the sequential PC increment.
// Optional trap support in the sequencer is enabled with macro PCSEQ_TRAP_EN.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0080;
  localparam int unsigned PC_INC           = 4;

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel
// Combinational next-PC selection for the single-cycle MIPS fetch sequencer.
// Priority: trap (PCSEQ_TRAP_EN only) > jr > jump > branch > sequential.
// Ports:
//   pc              current PC
//   branch_taken    conditional branch resolved taken
//   branch_offset   sign-extended word offset
//   jump/jump_index J/JAL and its 26-bit index
//   jr/jr_target    JR/JALR and the rs value
//   trap_req        external trap request (PCSEQ_TRAP_EN only)
//   trap_sel        trap selected this instruction (PCSEQ_TRAP_EN only)
//   pc_plus4        pc + 4
//   next_pc         selected next PC
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int                  PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR = PC_WIDTH'(TRAP_VECTOR_DEF)
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_offset,
  input  logic                jump,
  input  logic [25:0]         jump_index,
  input  logic                jr,
  input  logic [PC_WIDTH-1:0] jr_target,
`ifdef PCSEQ_TRAP_EN
  input  logic                trap_req,
  output logic                trap_sel,
`endif
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic [PC_WIDTH-1:0] next_pc
);

  logic trap_w;

`ifdef PCSEQ_TRAP_EN
  // A misaligned JR target is a fault rather than being silently masked.
  assign trap_w   = trap_req | (jr & (jr_target[1:0] != 2'b00));
  assign trap_sel = trap_w;
`else
  assign trap_w   = 1'b0;
`endif

  assign pc_plus4 = pc + PC_WIDTH'(PC_INC);

  always_comb begin
    next_pc = pc_plus4;
    if (trap_w) begin
      next_pc = TRAP_VECTOR;
    end else if (jr) begin
      // Low two bits are dropped so fetch stays word aligned.
      next_pc = jr_target & ~PC_WIDTH'(3);
    end else if (jump) begin
      next_pc = {pc_plus4[PC_WIDTH-1:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      // Modulo 2^PC_WIDTH; wrap-around is architecturally legal.
      next_pc = pc_plus4 + (branch_offset << 2);
    end
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl
// Fetch/PC sequencer for the single-cycle MIPS core. Owns the architectural
// PC, runs the imem request/ack handshake and issues one instr_valid strobe
// per instruction. Optional trap support is enabled with macro PCSEQ_TRAP_EN.
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-low reset
//   imem_req/imem_addr  fetch request and address (held until imem_ack)
//   imem_ack            instruction data valid
//   instr_valid         one-cycle execute/commit strobe
//   branch_*, jump*, jr*, halt   redirect controls, sampled in EXEC only
//   resume              leave HALTED
//   pc, pc_plus4        current PC and its link value
//   retired_cnt         executed-instruction count (wraps)
//   state               FSM state for debug
//   trap_req, epc, trap_taken    (PCSEQ_TRAP_EN only)
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF),
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = PC_WIDTH'(TRAP_VECTOR_DEF)
) (
  input  logic                CLK,
  input  logic                RST,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  output logic                instr_valid,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_offset,
  input  logic                jump,
  input  logic [25:0]         jump_index,
  input  logic                jr,
  input  logic [PC_WIDTH-1:0] jr_target,
  input  logic                halt,
  input  logic                resume,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic [31:0]         retired_cnt,
  output logic [1:0]          state
`ifdef PCSEQ_TRAP_EN
  ,
  input  logic                trap_req,
  output logic [PC_WIDTH-1:0] epc,
  output logic                trap_taken
`endif
);

  state_e              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [31:0]         cnt_q;
  logic [PC_WIDTH-1:0] next_pc_d;
`ifdef PCSEQ_TRAP_EN
  logic [PC_WIDTH-1:0] epc_q;
  logic                trap_sel;
`endif

  pc_next_sel #(
    .PC_WIDTH    (PC_WIDTH),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_next_sel (
    .pc            (pc_q),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
`ifdef PCSEQ_TRAP_EN
    .trap_req      (trap_req),
    .trap_sel      (trap_sel),
`endif
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc_d)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
`ifdef PCSEQ_TRAP_EN
      epc_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE:   state_q <= ST_FETCH;
        ST_FETCH:  if (imem_ack) state_q <= ST_EXEC;
        ST_EXEC: begin
          pc_q  <= next_pc_d;
          cnt_q <= cnt_q + 32'd1;
`ifdef PCSEQ_TRAP_EN
          // A trap overrides halt: the handler must be fetched.
          if (trap_sel) begin
            epc_q   <= pc_q;
            state_q <= ST_FETCH;
          end else
`endif
          if (halt) state_q <= ST_HALTED;
          else      state_q <= ST_FETCH;
        end
        ST_HALTED: if (resume) state_q <= ST_FETCH;
      endcase
    end
  end

  // Handshake outputs decode the state register only, so they fall as soon
  // as reset asserts.
  assign imem_req    = (state_q == ST_FETCH);
  assign instr_valid = (state_q == ST_EXEC);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign retired_cnt = cnt_q;
  assign state       = state_q;
`ifdef PCSEQ_TRAP_EN
  assign epc         = epc_q;
  assign trap_taken  = (state_q == ST_EXEC) && trap_sel;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl
// Scoreboard bench for pc_seq_ctrl: each executed instruction pushes the
// fetch address it should lead to; the next FETCH pops and compares it.
// Trap scenario is compiled only with PCSEQ_TRAP_EN.
module tb_pc_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        instr_valid;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = '0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = '0;
  logic        halt = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired_cnt;
  logic [1:0]  state;
`ifdef PCSEQ_TRAP_EN
  logic        trap_req = 1'b0;
  logic [31:0] epc;
  logic        trap_taken;
`endif

  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_cnt = '0;
  logic [31:0] e;

  pc_seq_ctrl dut (
    .CLK           (CLK),
    .RST           (RST),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .instr_valid   (instr_valid),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .halt          (halt),
    .resume        (resume),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .retired_cnt   (retired_cnt),
    .state         (state)
`ifdef PCSEQ_TRAP_EN
    ,
    .trap_req      (trap_req),
    .epc           (epc),
    .trap_taken    (trap_taken)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_redirect();
    branch_taken  = 1'b0;
    branch_offset = '0;
    jump          = 1'b0;
    jump_index    = '0;
    jr            = 1'b0;
    jr_target     = '0;
    halt          = 1'b0;
    resume        = 1'b0;
`ifdef PCSEQ_TRAP_EN
    trap_req      = 1'b0;
`endif
  endtask

  // From FETCH with imem_ack=1: enter EXEC, drive redirects, push the
  // expected fetch address, and land in the following state.
  task automatic step_exec(input logic br, input logic [31:0] off,
                           input logic j, input logic [25:0] idx,
                           input logic jrr, input logic [31:0] tgt,
                           input logic [31:0] exp_next);
    tick();
    branch_taken  = br;
    branch_offset = off;
    jump          = j;
    jump_index    = idx;
    jr            = jrr;
    jr_target     = tgt;
    exp_q.push_back(exp_next);
    exp_cnt = exp_cnt + 32'd1;
    tick();
    clear_redirect();
  endtask

  task automatic test_reset();
    #2 RST = 1'b0;
    #1;
    checks++; if (state !== 2'd0) $display("FAIL rst_state got %0d want 0", state); else passes++;
    checks++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", imem_req); else passes++;
    checks++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", instr_valid); else passes++;
    checks++; if (pc !== 32'h0) $display("FAIL rst_pc got %h want 0", pc); else passes++;
    checks++; if (retired_cnt !== 32'h0) $display("FAIL rst_cnt got %h want 0", retired_cnt); else passes++;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    imem_ack = 1'b1;
    exp_q.push_back(32'h0);
    checks++; if (state !== 2'd0) $display("FAIL rel_idle got %0d want 0", state); else passes++;
    tick();
    checks++; if (state !== 2'd1 || imem_req !== 1'b1) $display("FAIL rel_fetch state %0d req %b want 1/1", state, imem_req); else passes++;
    e = exp_q.pop_front();
    checks++; if (imem_addr !== e) $display("FAIL rel_addr got %h want %h", imem_addr, e); else passes++;
    tick();
    checks++; if (state !== 2'd2 || instr_valid !== 1'b1) $display("FAIL rel_exec state %0d valid %b want 2/1", state, instr_valid); else passes++;
    exp_q.push_back(32'h4);
    exp_cnt = exp_cnt + 32'd1;
    tick();
    e = exp_q.pop_front();
    checks++; if (imem_addr !== e) $display("FAIL seq_addr got %h want %h", imem_addr, e); else passes++;
    checks++; if (retired_cnt !== exp_cnt) $display("FAIL seq_cnt got %0d want %0d", retired_cnt, exp_cnt); else passes++;
  endtask

  task automatic test_delayed_ack();
    int pulses;
    step_exec(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h8);
    imem_ack = 1'b0;
    e = exp_q.pop_front();
    checks++; if (imem_addr !== e) $display("FAIL dly_addr got %h want %h", imem_addr, e); else passes++;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8)
        $display("FAIL dly_hold[%0d] req %b addr %h want 1/00000008", i, imem_req, imem_addr);
      else passes++;
      pulses += int'(instr_valid);
      if (i == 2) imem_ack = 1'b1;
      tick();
    end
    pulses += int'(instr_valid);
    exp_q.push_back(32'hC);
    exp_cnt = exp_cnt + 32'd1;
    tick();
    pulses += int'(instr_valid);
    checks++; if (pulses != 1) $display("FAIL dly_pulses got %0d want 1", pulses); else passes++;
    e = exp_q.pop_front();
    checks++; if (imem_addr !== e) $display("FAIL dly_next got %h want %h", imem_addr, e); else passes++;
    checks++; if (retired_cnt !== exp_cnt) $display("FAIL dly_cnt got %0d want %0d", retired_cnt, exp_cnt); else passes++;
  endtask

  task automatic test_redirects();
    step_exec(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h100, 32'h100);
    e = exp_q.pop_front();
    checks++; if (imem_addr !== e) $display("FAIL jr_addr got %h want %h", imem_addr, e); else passes++;
    step_exec(1'b1, 32'hFFFF_FFFF, 1'b0, 26'h0, 1'b0, 32'h0, 32'h100);
    e = exp_q.pop_front();
    checks++; if (imem_addr !== e) $display("FAIL br_neg got %h want %h", imem_addr, e); else passes++;
    step_exec(1'b1, 32'hFFFF_FFFF, 1'b0, 26'h0, 1'b1, 32'h2000, 32'h2000);
    e = exp_q.pop_front();
    checks++; if (imem_addr !== e) $display("FAIL jr_over_br got %h want %h", imem_addr, e); else passes++;
`ifdef PCSEQ_TRAP_EN
    step_exec(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h1000_0010, 32'h1000_0010);
`else
    step_exec(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h1000_0013, 32'h1000_0010);
`endif
    e = exp_q.pop_front();
    checks++; if (imem_addr !== e) $display("FAIL jr_mask got %h want %h", imem_addr, e); else passes++;
    step_exec(1'b1, 32'h5, 1'b1, 26'h40, 1'b0, 32'h0, 32'h1000_0100);
    e = exp_q.pop_front();
    checks++; if (imem_addr !== e) $display("FAIL jump got %h want %h", imem_addr, e); else passes++;
    checks++; if (pc_plus4 !== 32'h1000_0104) $display("FAIL pc_plus4 got %h want 10000104", pc_plus4); else passes++;
    step_exec(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h0, 32'h0);
    e = exp_q.pop_front();
    checks++; if (imem_addr !== e) $display("FAIL jr_zero got %h want %h", imem_addr, e); else passes++;
    step_exec(1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0, 1'b0, 32'h0, 32'hFFFF_FFFC);
    e = exp_q.pop_front();
    checks++; if (imem_addr !== e) $display("FAIL br_wrap got %h want %h", imem_addr, e); else passes++;
    step_exec(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0);
    e = exp_q.pop_front();
    checks++; if (imem_addr !== e) $display("FAIL seq_wrap got %h want %h", imem_addr, e); else passes++;
  endtask

  task automatic test_halt();
    logic req_seen;
    tick();
    halt       = 1'b1;
    resume     = 1'b1;
    jump       = 1'b1;
    jump_index = 26'h10;
    exp_cnt = exp_cnt + 32'd1;
    tick();
    clear_redirect();
    checks++; if (state !== 2'd3) $display("FAIL halt_state got %0d want 3", state); else passes++;
    checks++; if (pc !== 32'h40) $display("FAIL halt_pc got %h want 00000040", pc); else passes++;
    checks++; if (retired_cnt !== exp_cnt) $display("FAIL halt_cnt got %0d want %0d", retired_cnt, exp_cnt); else passes++;
    req_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_seen = req_seen | imem_req | instr_valid;
      tick();
    end
    checks++; if (req_seen !== 1'b0) $display("FAIL halt_idle got %b want 0", req_seen); else passes++;
    checks++; if (state !== 2'd3 || pc !== 32'h40) $display("FAIL halt_hold state %0d pc %h want 3/00000040", state, pc); else passes++;
    resume = 1'b1;
    exp_q.push_back(32'h40);
    tick();
    resume = 1'b0;
    checks++; if (state !== 2'd1 || imem_req !== 1'b1) $display("FAIL resume state %0d req %b want 1/1", state, imem_req); else passes++;
    e = exp_q.pop_front();
    checks++; if (imem_addr !== e) $display("FAIL resume_addr got %h want %h", imem_addr, e); else passes++;
  endtask

  task automatic test_reset_mid_fetch();
    step_exec(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h24, 32'h24);
    imem_ack = 1'b0;
    e = exp_q.pop_front();
    checks++; if (imem_addr !== e) $display("FAIL mf_addr got %h want %h", imem_addr, e); else passes++;
    tick();
    checks++; if (imem_req !== 1'b1) $display("FAIL mf_req got %b want 1", imem_req); else passes++;
    #2 RST = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) $display("FAIL mf_rst_req got %b want 0", imem_req); else passes++;
    checks++; if (pc !== 32'h0 || state !== 2'd0) $display("FAIL mf_rst pc %h state %0d want 0/0", pc, state); else passes++;
    @(negedge CLK);
    RST = 1'b1;
    imem_ack = 1'b1;
    exp_cnt = '0;
    tick();
    checks++; if (state !== 2'd1 || instr_valid !== 1'b0) $display("FAIL mf_late_ack state %0d valid %b want 1/0", state, instr_valid); else passes++;
    checks++; if (imem_addr !== 32'h0 || retired_cnt !== 32'h0) $display("FAIL mf_after addr %h cnt %0d want 0/0", imem_addr, retired_cnt); else passes++;
  endtask

`ifdef PCSEQ_TRAP_EN
  task automatic test_trap();
    step_exec(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h50, 32'h50);
    e = exp_q.pop_front();
    checks++; if (imem_addr !== e) $display("FAIL trap_pre got %h want %h", imem_addr, e); else passes++;
    tick();
    jr        = 1'b1;
    jr_target = 32'h302;
    halt      = 1'b1;
    #1;
    checks++; if (trap_taken !== 1'b1) $display("FAIL trap_pulse got %b want 1", trap_taken); else passes++;
    exp_q.push_back(32'h80);
    tick();
    clear_redirect();
    checks++; if (trap_taken !== 1'b0) $display("FAIL trap_once got %b want 0", trap_taken); else passes++;
    checks++; if (epc !== 32'h50) $display("FAIL trap_epc got %h want 00000050", epc); else passes++;
    checks++; if (state !== 2'd1) $display("FAIL trap_state got %0d want 1", state); else passes++;
    e = exp_q.pop_front();
    checks++; if (pc !== e) $display("FAIL trap_pc got %h want %h", pc, e); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_delayed_ack();
    test_redirects();
    test_halt();
    test_reset_mid_fetch();
`ifdef PCSEQ_TRAP_EN
    test_trap();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
